// File: rtl/pll_ctrl_if.sv
// Signal bundle between pll_ctrl and its surroundings: CSR request/response,
// PLL pins and status flags.
interface pll_ctrl_if;
  logic       io_req_valid;
  logic       io_req_ready;
  logic [7:0] io_req_mul;
  logic       io_rsp_valid;
  logic [1:0] io_rsp_err;
  logic       io_pll_bypass;
  logic [7:0] io_pll_mul;
  logic       io_pll_lock;
  logic       io_locked;
  logic       io_lock_lost;

  // Everything around the controller: CSR block plus the PLL lock pin.
  modport master (
    output io_req_valid, io_req_mul, io_pll_lock,
    input  io_req_ready, io_rsp_valid, io_rsp_err, io_pll_bypass,
    input  io_pll_mul, io_locked, io_lock_lost
  );

  // The sequencer itself.
  modport slave (
    input  io_req_valid, io_req_mul, io_pll_lock,
    output io_req_ready, io_rsp_valid, io_rsp_err, io_pll_bypass,
    output io_pll_mul, io_locked, io_lock_lost
  );
endinterface

// File: rtl/pll_ctrl.sv
// PLL frequency-change sequencer: forces bypass, reprograms mul, waits for a
// stable lock with timeout, then releases bypass. Runs on the reference clock.
module pll_ctrl #(
  parameter logic [7:0]  INIT_MUL    = 8'd4,
  parameter int unsigned GUARD_CYC   = 4,
  parameter int unsigned MASK_CYC    = 4,
  parameter int unsigned STABLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic       clock,
  input logic       reset_n,
  pll_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] GUARD_LD   = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] MASK_LD    = CNT_W'(MASK_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LD  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_TMO = 2'd1;
  localparam logic [1:0] ERR_MUL = 2'd2;

  localparam logic [2:0] S_BYPASS = 3'd0;
  localparam logic [2:0] S_PROG   = 3'd1;
  localparam logic [2:0] S_MASK   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  logic             r_lk_meta;
  logic             r_lk;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_pend_mul;
  logic             r_bypass;
  logic [7:0]       r_mul;
  logic             r_ready;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_err;
  logic             r_locked;
  logic             r_lock_lost;

  logic [2:0]       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [7:0]       w_pend_mul_nx;
  logic [7:0]       w_mul_nx;
  logic             w_rsp_valid_nx;
  logic [1:0]       w_rsp_err_nx;
  logic             w_lock_lost_nx;
  logic             w_bypass_nx;
  logic             w_ready_nx;
  logic             w_locked_nx;
  logic             w_accept;
  logic             w_cnt_zero;

  // Two-flop synchroniser for the asynchronous PLL lock pin.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lk_meta <= 1'b0;
      r_lk      <= 1'b0;
    end else begin
      r_lk_meta <= bus.io_pll_lock;
      r_lk      <= r_lk_meta;
    end
  end

  // Sequencer next-state, shared counter and registered output values.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    w_pend_mul_nx  = r_pend_mul;
    w_mul_nx       = r_mul;
    w_rsp_valid_nx = 1'b0;
    w_rsp_err_nx   = r_rsp_err;
    w_lock_lost_nx = r_lock_lost;
    w_accept       = bus.io_req_valid && r_ready;
    w_cnt_zero     = (r_cnt == '0);

    case (r_state)
      S_BYPASS: begin
        if (w_cnt_zero) begin
          w_mul_nx   = r_pend_mul;
          w_state_nx = S_PROG;
        end
      end
      S_PROG: begin
        w_cnt_nx   = MASK_LD;
        w_state_nx = S_MASK;
      end
      S_MASK: begin
        // Lock is ignored here: the PLL drops it shortly after a mul change.
        if (w_cnt_zero) begin
          w_cnt_nx   = TIMEOUT_LD;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lk) begin
          w_cnt_nx   = STABLE_LD;
          w_state_nx = S_SETTLE;
        end else if (w_cnt_zero) begin
          w_state_nx     = S_FAIL;
          w_rsp_valid_nx = 1'b1;
          w_rsp_err_nx   = ERR_TMO;
        end
      end
      S_SETTLE: begin
        // A lock drop restarts the attempt with a full timeout window.
        if (!r_lk) begin
          w_cnt_nx   = TIMEOUT_LD;
          w_state_nx = S_WAIT;
        end else if (w_cnt_zero) begin
          w_state_nx     = S_RUN;
          w_rsp_valid_nx = 1'b1;
          w_rsp_err_nx   = ERR_OK;
        end
      end
      S_RUN, S_FAIL: begin
        // An accepted request wins over a simultaneous lock loss; a lock
        // still low is picked up on the following cycle.
        if (w_accept) begin
          if (bus.io_req_mul == 8'd0) begin
            w_rsp_valid_nx = 1'b1;
            w_rsp_err_nx   = ERR_MUL;
          end else if ((r_state == S_RUN) && (bus.io_req_mul == r_mul)) begin
            w_rsp_valid_nx = 1'b1;
            w_rsp_err_nx   = ERR_OK;
          end else begin
            w_pend_mul_nx  = bus.io_req_mul;
            w_lock_lost_nx = 1'b0;
            w_cnt_nx       = GUARD_LD;
            w_state_nx     = S_BYPASS;
          end
        end else if ((r_state == S_RUN) && !r_lk) begin
          w_lock_lost_nx = 1'b1;
          w_cnt_nx       = TIMEOUT_LD;
          w_state_nx     = S_WAIT;
        end
      end
      default: begin
        w_cnt_nx   = GUARD_LD;
        w_state_nx = S_BYPASS;
      end
    endcase

    w_bypass_nx = (w_state_nx != S_RUN);
    w_ready_nx  = (w_state_nx == S_RUN) || (w_state_nx == S_FAIL);
    w_locked_nx = (w_state_nx == S_RUN);
  end

  // State, counter and output registers; reset restarts bring-up at INIT_MUL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_BYPASS;
      r_cnt       <= GUARD_LD;
      r_pend_mul  <= INIT_MUL;
      r_mul       <= INIT_MUL;
      r_bypass    <= 1'b1;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= ERR_OK;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_pend_mul  <= w_pend_mul_nx;
      r_mul       <= w_mul_nx;
      r_bypass    <= w_bypass_nx;
      r_ready     <= w_ready_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_err   <= w_rsp_err_nx;
      r_locked    <= w_locked_nx;
      r_lock_lost <= w_lock_lost_nx;
    end
  end

  assign bus.io_req_ready  = r_ready;
  assign bus.io_rsp_valid  = r_rsp_valid;
  assign bus.io_rsp_err    = r_rsp_err;
  assign bus.io_pll_bypass = r_bypass;
  assign bus.io_pll_mul    = r_mul;
  assign bus.io_locked     = r_locked;
  assign bus.io_lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_pll_ctrl.sv
// Bench for pll_ctrl: PLL lock stimulus, deadline-based reference model
// compared every cycle, plus hand-computed timing anchors.
module tb_pll_ctrl;

  localparam int unsigned GUARD  = 4;
  localparam int unsigned MASK   = 4;
  localparam int unsigned STABLE = 16;
  localparam int unsigned TMO    = 50;
  localparam logic [7:0]  INIT_MUL = 8'd4;

  localparam int PH_GUARD  = 0;
  localparam int PH_PROG   = 1;
  localparam int PH_MASK   = 2;
  localparam int PH_WAIT   = 3;
  localparam int PH_SETTLE = 4;
  localparam int PH_RUN    = 5;
  localparam int PH_FAIL   = 6;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   tb_cyc;
  logic tie0;
  int   force_until;

  pll_ctrl_if bus ();

  pll_ctrl #(
    .INIT_MUL   (INIT_MUL),
    .GUARD_CYC  (GUARD),
    .MASK_CYC   (MASK),
    .STABLE_CYC (STABLE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Edge counter since last reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PLL lock behaviour: drops on every mul change and relocks after a random
  // delay; can be tied low or glitched low for a window.
  initial begin : pll_drv
    logic [7:0] seen;
    logic       lk;
    int         cnt;
    seen = INIT_MUL;
    lk   = 1'b1;
    cnt  = 0;
    bus.io_pll_lock = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (bus.io_pll_mul !== seen) begin
        seen = bus.io_pll_mul;
        lk   = 1'b0;
        cnt  = $urandom_range(35, 10);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) lk = 1'b1;
      end
      bus.io_pll_lock = (tie0 || (tb_cyc < force_until)) ? 1'b0 : lk;
    end
  end

  // Reference model: phases with absolute deadlines instead of a counter.
  int         m_phase;
  int         m_dl;
  int         m_t;
  logic [7:0] m_mul;
  logic [7:0] m_pend;
  logic       m_rsp_v;
  logic [1:0] m_err;
  logic       m_lost;
  logic       m_meta;
  logic       m_lk;

  initial begin : model
    int  tn;
    logic acc;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_phase = PH_GUARD; m_dl = GUARD; m_t = 0;
        m_mul = INIT_MUL; m_pend = INIT_MUL;
        m_rsp_v = 1'b0; m_err = 2'd0; m_lost = 1'b0;
        m_meta = 1'b0; m_lk = 1'b0;
      end else begin
        tn = m_t + 1;
        acc = bus.io_req_valid && (m_phase == PH_RUN || m_phase == PH_FAIL);
        m_rsp_v = 1'b0;
        case (m_phase)
          PH_GUARD:  if (tn == m_dl) begin m_mul = m_pend; m_phase = PH_PROG; m_dl = tn + 1; end
          PH_PROG:   begin m_phase = PH_MASK; m_dl = tn + MASK; end
          PH_MASK:   if (tn == m_dl) begin m_phase = PH_WAIT; m_dl = tn + TMO; end
          PH_WAIT: begin
            if (m_lk) begin m_phase = PH_SETTLE; m_dl = tn + STABLE; end
            else if (tn == m_dl) begin m_phase = PH_FAIL; m_rsp_v = 1'b1; m_err = 2'd1; end
          end
          PH_SETTLE: begin
            if (!m_lk) begin m_phase = PH_WAIT; m_dl = tn + TMO; end
            else if (tn == m_dl) begin m_phase = PH_RUN; m_rsp_v = 1'b1; m_err = 2'd0; end
          end
          default: begin
            if (acc) begin
              if (bus.io_req_mul == 8'd0) begin
                m_rsp_v = 1'b1; m_err = 2'd2;
              end else if (m_phase == PH_RUN && bus.io_req_mul == m_mul) begin
                m_rsp_v = 1'b1; m_err = 2'd0;
              end else begin
                m_pend = bus.io_req_mul; m_lost = 1'b0;
                m_phase = PH_GUARD; m_dl = tn + GUARD;
              end
            end else if (m_phase == PH_RUN && !m_lk) begin
              m_lost = 1'b1; m_phase = PH_WAIT; m_dl = tn + TMO;
            end
          end
        endcase
        m_t = tn;
        m_lk = m_meta;
        m_meta = bus.io_pll_lock;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      chk("bypass",    32'(bus.io_pll_bypass), 32'(m_phase != PH_RUN));
      chk("mul",       32'(bus.io_pll_mul),    32'(m_mul));
      chk("ready",     32'(bus.io_req_ready),  32'(m_phase == PH_RUN || m_phase == PH_FAIL));
      chk("locked",    32'(bus.io_locked),     32'(m_phase == PH_RUN));
      chk("lock_lost", 32'(bus.io_lock_lost),  32'(m_lost));
      chk("rsp_valid", 32'(bus.io_rsp_valid),  32'(m_rsp_v));
      if (m_rsp_v) chk("rsp_err", 32'(bus.io_rsp_err), 32'(m_err));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bypass"}, 32'(bus.io_pll_bypass), 32'd1);
    chk({tag, "_mul"},    32'(bus.io_pll_mul),    32'd4);
    chk({tag, "_ready"},  32'(bus.io_req_ready),  32'd0);
    chk({tag, "_rsp"},    32'(bus.io_rsp_valid),  32'd0);
    chk({tag, "_locked"}, 32'(bus.io_locked),     32'd0);
    chk({tag, "_lost"},   32'(bus.io_lock_lost),  32'd0);
  endtask

  task automatic pulse_reset();
    force_until = 0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Wait for a response pulse; returns the edge number and error code.
  task automatic wait_rsp(input int max_cyc, output int edge_n, output int err);
    edge_n = -1;
    err    = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (bus.io_rsp_valid === 1'b1) begin
        edge_n = tb_cyc;
        err    = int'(bus.io_rsp_err);
        return;
      end
    end
    chk("rsp_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_locked(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (bus.io_locked === 1'b1) return;
    end
    chk("locked_wait_timeout", 32'd0, 32'd1);
  endtask

  // Wait for ready, present one request for one edge; returns accept edge.
  task automatic do_req(input logic [7:0] mul, input bit use_cur, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    @(posedge clock); #2;
    while (bus.io_req_ready !== 1'b1 && n < 500) begin
      @(posedge clock); #2;
      n++;
    end
    if (n >= 500) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.io_req_valid = 1'b1;
    bus.io_req_mul   = use_cur ? bus.io_pll_mul : mul;
    @(posedge clock); #2;
    acc_cyc = tb_cyc;
    bus.io_req_valid = 1'b0;
    bus.io_req_mul   = 8'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e, er, acc;
    bit found;
    checks = 0; errors = 0;
    bus.io_req_valid = 1'b0;
    bus.io_req_mul   = 8'd0;
    tie0 = 1'b0;
    force_until = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk_reset_vals("rst");
    @(negedge clock) reset_n = 1'b1;

    // Bring-up with steady lock: 4 guard + 1 prog + 4 mask + 1 wait + 16 settle.
    wait_rsp(200, e, er);
    chk("bringup_edge", 32'(e), 32'd26);
    chk("bringup_err",  32'(er), 32'd0);
    @(negedge clock);
    chk("bringup_locked", 32'(bus.io_locked), 32'd1);
    chk("bringup_bypass", 32'(bus.io_pll_bypass), 32'd0);

    // Change to mul 8.
    do_req(8'd8, 1'b0, acc);
    @(negedge clock);
    chk("req8_bypass", 32'(bus.io_pll_bypass), 32'd1);
    chk("req8_ready",  32'(bus.io_req_ready),  32'd0);
    wait_rsp(300, e, er);
    chk("req8_err", 32'(er), 32'd0);
    @(negedge clock);
    chk("req8_mul", 32'(bus.io_pll_mul), 32'd8);

    // Illegal mul, then same mul: both answer on the next cycle.
    do_req(8'd0, 1'b0, acc);
    @(negedge clock);
    chk("mul0_rsp",    32'(bus.io_rsp_valid),  32'd1);
    chk("mul0_err",    32'(bus.io_rsp_err),    32'd2);
    chk("mul0_bypass", 32'(bus.io_pll_bypass), 32'd0);
    chk("mul0_locked", 32'(bus.io_locked),     32'd1);
    do_req(8'd8, 1'b0, acc);
    @(negedge clock);
    chk("same_rsp",    32'(bus.io_rsp_valid),  32'd1);
    chk("same_err",    32'(bus.io_rsp_err),    32'd0);
    chk("same_bypass", 32'(bus.io_pll_bypass), 32'd0);

    // Lock glitch in RUN.
    @(posedge clock); #2;
    force_until = tb_cyc + 6;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clock);
      if (bus.io_pll_bypass === 1'b1) found = 1'b1;
    end
    chk("lost_bypass_seen", 32'(found), 32'd1);
    chk("lost_flag", 32'(bus.io_lock_lost), 32'd1);
    wait_locked(400);
    chk("lost_sticky", 32'(bus.io_lock_lost), 32'd1);
    do_req(8'd5, 1'b0, acc);
    @(negedge clock);
    chk("lost_cleared", 32'(bus.io_lock_lost), 32'd0);
    wait_rsp(300, e, er);
    chk("req5_err", 32'(er), 32'd0);

    // Lock tied low: timeout at 4 + 1 + 4 + 50.
    tie0 = 1'b1;
    pulse_reset();
    wait_rsp(200, e, er);
    chk("tmo_edge", 32'(e), 32'd59);
    chk("tmo_err",  32'(er), 32'd1);
    @(negedge clock);
    chk("tmo_bypass", 32'(bus.io_pll_bypass), 32'd1);
    chk("tmo_ready",  32'(bus.io_req_ready),   32'd1);
    tie0 = 1'b0;
    do_req(8'd6, 1'b0, acc);
    wait_rsp(300, e, er);
    chk("retry_err", 32'(er), 32'd0);

    // Reset in the middle of the lock wait.
    tie0 = 1'b1;
    pulse_reset();
    for (int i = 0; i < 100 && tb_cyc < 30; i++) @(negedge clock);
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("rst_wait");
    @(negedge clock);
    tie0 = 1'b0;
    reset_n = 1'b1;
    wait_rsp(300, e, er);
    chk("rst_wait_err", 32'(er), 32'd0);

    // Reset during settle after a one-cycle lock glitch.
    repeat (5) @(negedge clock);
    pulse_reset();
    for (int i = 0; i < 100 && tb_cyc < 13; i++) @(negedge clock);
    force_until = tb_cyc + 2;
    for (int i = 0; i < 100 && tb_cyc < 20; i++) @(negedge clock);
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("rst_settle");
    @(negedge clock) reset_n = 1'b1;
    wait_rsp(300, e, er);
    chk("rst_settle_err", 32'(er), 32'd0);

    // Random requests and lock glitches.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(15, 0)) @(posedge clock);
      case ($urandom_range(3, 0))
        0: begin
          @(posedge clock); #2;
          force_until = tb_cyc + int'($urandom_range(7, 2));
        end
        1: do_req(8'd0, 1'b0, acc);
        2: do_req(8'd0, 1'b1, acc);
        default: do_req(8'($urandom_range(255, 1)), 1'b0, acc);
      endcase
    end
    wait_locked(400);
    repeat (20) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
